uart_master_top: RTL and testbench

UART_MASTER_TOP -- requirements
Module: uart_master_top

---
 rtl/uart_master_pkg.sv | 43 ++++
 rtl/uart_fifo.sv | 48 ++++
 rtl/uart_master_top.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_master_top.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_master_pkg.sv
// Shared constants for the 8N1 UART master: register map, status/enable bit
// positions, frame geometry, FSM state types and the baud divisor helper.
package uart_master_pkg;

   localparam logic [2:0] ADDR_RHR = 3'd0;
   localparam logic [2:0] ADDR_IER = 3'd1;
   localparam logic [2:0] ADDR_ISR = 3'd2;
   localparam logic [2:0] ADDR_LCR = 3'd3;
   localparam logic [2:0] ADDR_MCR = 3'd4;
   localparam logic [2:0] ADDR_LSR = 3'd5;
   localparam logic [2:0] ADDR_MSR = 3'd6;
   localparam logic [2:0] ADDR_SCR = 3'd7;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_FE   = 3;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam int IER_RDA  = 0;
   localparam int IER_THRE = 1;

   localparam int FCR_RX_FLUSH = 1;
   localparam int FCR_TX_FLUSH = 2;

   localparam logic [7:0] ISR_RDA  = 8'h04;
   localparam logic [7:0] ISR_THRE = 8'h02;
   localparam logic [7:0] ISR_NONE = 8'h01;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;   // start + 8 data + stop
   localparam int OSR        = 16;
   localparam int FIFO_DEPTH = 16;

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Clocks per oversampling tick, rounded to nearest.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + (OSR / 2) * baud) / (OSR * baud);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the optional RX/TX buffering. A push into a full FIFO
// is accepted when a pop happens on the same cycle.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_master_top.sv
// 8N1 UART with a 16550-style register file and 16x oversampling.
// Define UART_FIFO_EN to replace the single RHR/THR holding registers with 16-deep FIFOs.
module uart_master_top
   import uart_master_pkg::*;
#(
   parameter int CLK_FREQ = 27000000,
   parameter int BAUD     = 115200
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_TX_EN,
   input  logic [2:0] I_WADDR,
   input  logic [7:0] I_WDATA,
   input  logic       I_RX_EN,
   input  logic [2:0] I_RADDR,
   output logic [7:0] O_RDATA,
   input  logic       SIN,
   output logic       RxRDYn,
   output logic       SOUT,
   output logic       TxRDYn,
   output logic       DDIS,
   output logic       INTR,
   input  logic       DCDn,
   input  logic       CTSn,
   input  logic       DSRn,
   input  logic       RIn,
   output logic       DTRn,
   output logic       RTSn
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [7:0] ier, lcr, mcr, scr, lsr, isr, msr;
   logic       oe, fe, dr, thre, lsr_rd;
   logic       tx_push, tx_pop, tx_empty, tx_full;
   logic       rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0] tx_dout, rx_dout, rx_shreg;

   assign tx_push = I_TX_EN && (I_WADDR == ADDR_RHR);
   assign rx_pop  = I_RX_EN && (I_RADDR == ADDR_RHR) && !rx_empty;
   assign lsr_rd  = I_RX_EN && (I_RADDR == ADDR_LSR);

`ifdef UART_FIFO_EN
   logic tx_flush, rx_flush;
   assign tx_flush = I_TX_EN && (I_WADDR == ADDR_ISR) && I_WDATA[FCR_TX_FLUSH];
   assign rx_flush = I_TX_EN && (I_WADDR == ADDR_ISR) && I_WDATA[FCR_RX_FLUSH];

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(I_CLK), .rst(I_RESET), .flush(tx_flush), .push(tx_push), .din(I_WDATA),
      .pop(tx_pop), .dout(tx_dout), .empty(tx_empty), .full(tx_full));

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(I_CLK), .rst(I_RESET), .flush(rx_flush), .push(rx_push), .din(rx_shreg),
      .pop(rx_pop), .dout(rx_dout), .empty(rx_empty), .full(rx_full));
`else
   logic [7:0] thr_q, rhr_q;
   logic       thr_vld, rhr_vld;

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         thr_q   <= '0;
         thr_vld <= 1'b0;
         rhr_q   <= '0;
         rhr_vld <= 1'b0;
      end else begin
         if (tx_push && !thr_vld) begin
            thr_q   <= I_WDATA;
            thr_vld <= 1'b1;
         end else if (tx_pop) begin
            thr_vld <= 1'b0;
         end
         // A pop on the arrival cycle frees the slot for the new byte.
         if (rx_push && (!rhr_vld || rx_pop)) begin
            rhr_q   <= rx_shreg;
            rhr_vld <= 1'b1;
         end else if (rx_pop) begin
            rhr_vld <= 1'b0;
         end
      end
   end

   assign tx_dout  = thr_q;
   assign tx_empty = !thr_vld;
   assign tx_full  = thr_vld;
   assign rx_dout  = rhr_q;
   assign rx_empty = !rhr_vld;
   assign rx_full  = rhr_vld;
`endif

   // Transmitter
   tx_state_t     tx_state, tx_next;
   logic [DW-1:0] tx_div;
   logic [3:0]    tx_os, tx_bit;
   logic [9:0]    tx_shreg;
   logic          tx_tick, tx_bit_end;

   assign tx_tick    = (tx_div == DIV_LAST);
   assign tx_bit_end = tx_tick && (tx_os == 4'(OSR - 1));

   always_ff @(posedge I_CLK) begin
      if (I_RESET) tx_state <= TX_IDLE;
      else         tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_next = TX_SEND;
         end
         TX_SEND: if (tx_bit_end && (tx_bit == 4'(FRAME_BITS - 1))) tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         tx_div   <= '0;
         tx_os    <= '0;
         tx_bit   <= '0;
         tx_shreg <= '1;
      end else if (tx_pop) begin
         tx_div   <= '0;
         tx_os    <= '0;
         tx_bit   <= '0;
         tx_shreg <= {1'b1, tx_dout, 1'b0};
      end else if (tx_state == TX_SEND) begin
         tx_div <= tx_tick ? '0 : tx_div + 1'b1;
         if (tx_tick) tx_os <= tx_os + 1'b1;
         if (tx_bit_end) begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shreg <= {1'b1, tx_shreg[9:1]};
         end
      end
   end

   assign SOUT = (tx_state == TX_SEND) ? tx_shreg[0] : 1'b1;
   assign DDIS = (tx_state == TX_IDLE);

   // Receiver
   rx_state_t     rx_state, rx_next;
   logic          sin_m, sin_s;
   logic [DW-1:0] rx_div;
   logic [3:0]    rx_os;
   logic [2:0]    rx_bit;
   logic          rx_tick, rx_mid, rx_end;

   assign rx_tick = (rx_div == DIV_LAST);
   assign rx_mid  = rx_tick && (rx_os == 4'(OSR / 2 - 1));
   assign rx_end  = rx_tick && (rx_os == 4'(OSR - 1));

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         sin_m    <= 1'b1;
         sin_s    <= 1'b1;
         rx_state <= RX_HUNT;
      end else begin
         sin_m    <= SIN;
         sin_s    <= sin_m;
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      case (rx_state)
         RX_HUNT:  if (!sin_s) rx_next = RX_START;
         RX_START: if (rx_mid) rx_next = sin_s ? RX_HUNT : RX_DATA;
         RX_DATA:  if (rx_end && (rx_bit == 3'(DATA_BITS - 1))) rx_next = RX_STOP;
         RX_STOP:  if (rx_end) begin
            rx_push = 1'b1;
            rx_next = RX_HUNT;
         end
         default:  rx_next = RX_HUNT;
      endcase
   end

   // Counters restart at the start edge so samples land on bit centres.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         rx_div   <= '0;
         rx_os    <= '0;
         rx_bit   <= '0;
         rx_shreg <= '0;
      end else if (rx_state == RX_HUNT) begin
         rx_div <= '0;
         rx_os  <= '0;
         rx_bit <= '0;
      end else begin
         rx_div <= rx_tick ? '0 : rx_div + 1'b1;
         if (rx_state == RX_START && rx_mid) rx_os <= '0;
         else if (rx_tick)                   rx_os <= rx_os + 1'b1;
         if (rx_state == RX_DATA && rx_end) begin
            rx_shreg <= {sin_s, rx_shreg[7:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
      end
   end

   // Register file and line status
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         ier <= '0;
         lcr <= '0;
         mcr <= '0;
         scr <= '0;
         oe  <= 1'b0;
         fe  <= 1'b0;
      end else begin
         if (I_TX_EN) begin
            case (I_WADDR)
               ADDR_IER: ier <= I_WDATA;
               ADDR_LCR: lcr <= I_WDATA;
               ADDR_MCR: mcr <= I_WDATA;
               ADDR_SCR: scr <= I_WDATA;
               default:  ;
            endcase
         end
         if (rx_push && rx_full && !rx_pop) oe <= 1'b1;
         else if (lsr_rd)                   oe <= 1'b0;
         if (rx_push && !sin_s) fe <= 1'b1;
         else if (lsr_rd)       fe <= 1'b0;
      end
   end

   assign TxRDYn = tx_full;
   assign RxRDYn = rx_empty;
   assign dr     = !rx_empty;
   assign thre   = !tx_full;

   always_comb begin
      lsr           = '0;
      lsr[LSR_DR]   = dr;
      lsr[LSR_OE]   = oe;
      lsr[LSR_FE]   = fe;
      lsr[LSR_THRE] = thre;
      lsr[LSR_TEMT] = thre && DDIS;
   end

   assign isr  = dr ? ISR_RDA : (thre ? ISR_THRE : ISR_NONE);
   assign msr  = {~DCDn, ~RIn, ~DSRn, ~CTSn, 4'b0000};
   assign INTR = (ier[IER_RDA] && dr) || (ier[IER_THRE] && thre);
   assign DTRn = ~mcr[0];
   assign RTSn = ~mcr[1];

   always_comb begin
      O_RDATA = 8'h00;
      case (I_RADDR)
         ADDR_RHR: O_RDATA = rx_dout;
         ADDR_IER: O_RDATA = ier;
         ADDR_ISR: O_RDATA = isr;
         ADDR_LCR: O_RDATA = lcr;
         ADDR_MCR: O_RDATA = mcr;
         ADDR_LSR: O_RDATA = lsr;
         ADDR_MSR: O_RDATA = msr;
         ADDR_SCR: O_RDATA = scr;
         default:  O_RDATA = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_master_top.sv
// Directed bench for uart_master_top at 27 MHz / 115200 baud (240 clocks per bit).
module tb_uart_master_top;

   logic       clk = 1'b0;
   logic       I_RESET = 1'b1;
   logic       I_TX_EN = 1'b0;
   logic [2:0] I_WADDR = '0;
   logic [7:0] I_WDATA = '0;
   logic       I_RX_EN = 1'b0;
   logic [2:0] I_RADDR = '0;
   logic [7:0] O_RDATA;
   logic       SIN = 1'b1;
   logic       RxRDYn, SOUT, TxRDYn, DDIS, INTR, DTRn, RTSn;
   logic       DCDn = 1'b1, CTSn = 1'b1, DSRn = 1'b1, RIn = 1'b1;

   int pass_cnt = 0;
   int total_cnt = 0;

   uart_master_top #(.CLK_FREQ(27000000), .BAUD(115200)) dut (
      .I_CLK(clk), .I_RESET(I_RESET), .I_TX_EN(I_TX_EN), .I_WADDR(I_WADDR),
      .I_WDATA(I_WDATA), .I_RX_EN(I_RX_EN), .I_RADDR(I_RADDR), .O_RDATA(O_RDATA),
      .SIN(SIN), .RxRDYn(RxRDYn), .SOUT(SOUT), .TxRDYn(TxRDYn), .DDIS(DDIS),
      .INTR(INTR), .DCDn(DCDn), .CTSn(CTSn), .DSRn(DSRn), .RIn(RIn),
      .DTRn(DTRn), .RTSn(RTSn));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Called at a negedge; the write lands on the following posedge.
   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      I_TX_EN = 1'b1; I_WADDR = a; I_WDATA = d;
      @(negedge clk);
      I_TX_EN = 1'b0;
   endtask

   // Drives one 8N1 frame; the stop level is held past the receiver's sample point.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 9; i++) begin
         SIN = fr[i];
         repeat (240) @(negedge clk);
      end
      SIN = stop_bit;
      repeat (160) @(negedge clk);
      SIN = 1'b1;
      repeat (80) @(negedge clk);
   endtask

   task automatic test_reset;
      I_RESET = 1'b1;
      repeat (3) @(negedge clk);
      I_RESET = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({SOUT, TxRDYn, RxRDYn, DDIS, INTR, DTRn, RTSn} !== 7'b1011011)
         $display("FAIL reset_outputs: got %b expected 1011011", {SOUT, TxRDYn, RxRDYn, DDIS, INTR, DTRn, RTSn});
      else pass_cnt++;
      I_RADDR = 3'd5; #1;
      total_cnt++;
      if (O_RDATA !== 8'h60) $display("FAIL reset_lsr: got %h expected 60", O_RDATA);
      else pass_cnt++;
      I_RADDR = 3'd2; #1;
      total_cnt++;
      if (O_RDATA !== 8'h02) $display("FAIL reset_isr: got %h expected 02", O_RDATA);
      else pass_cnt++;
   endtask

   task automatic test_regs;
      write_reg(3'd4, 8'h03);
      write_reg(3'd7, 8'h5A);
      write_reg(3'd3, 8'h1B);
      DCDn = 1'b0; RIn = 1'b1; DSRn = 1'b0; CTSn = 1'b1;
      #1;
      total_cnt++;
      if ({DTRn, RTSn} !== 2'b00) $display("FAIL mcr_outputs: got %b expected 00", {DTRn, RTSn});
      else pass_cnt++;
      I_RADDR = 3'd6; #1;
      total_cnt++;
      if (O_RDATA !== 8'hA0) $display("FAIL msr: got %h expected a0", O_RDATA);
      else pass_cnt++;
      I_RADDR = 3'd7; #1;
      total_cnt++;
      if (O_RDATA !== 8'h5A) $display("FAIL scr: got %h expected 5a", O_RDATA);
      else pass_cnt++;
      I_RADDR = 3'd3; #1;
      total_cnt++;
      if (O_RDATA !== 8'h1B) $display("FAIL lcr: got %h expected 1b", O_RDATA);
      else pass_cnt++;
      write_reg(3'd4, 8'h00);
      DCDn = 1'b1; DSRn = 1'b1;
   endtask

   task automatic test_tx;
      logic [9:0] exp_frame;
      exp_frame = 10'b1_0000_0110_0;
      write_reg(3'd0, 8'h06);
      @(negedge clk);
      total_cnt++;
      if ({TxRDYn, DDIS} !== 2'b00) $display("FAIL tx_start: got TxRDYn/DDIS %b expected 00", {TxRDYn, DDIS});
      else pass_cnt++;
      repeat (120) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (SOUT !== exp_frame[i]) $display("FAIL tx_bit%0d: got %b expected %b", i, SOUT, exp_frame[i]);
         else pass_cnt++;
         if (i < 9) repeat (240) @(negedge clk);
      end
      total_cnt++;
      if (DDIS !== 1'b0) $display("FAIL tx_ddis_busy: got %b expected 0", DDIS);
      else pass_cnt++;
      repeat (130) @(negedge clk);
      total_cnt++;
      if ({DDIS, SOUT} !== 2'b11) $display("FAIL tx_done: got DDIS/SOUT %b expected 11", {DDIS, SOUT});
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [9:0] exp_frame;
      exp_frame = {1'b1, 8'h22, 1'b0};
      write_reg(3'd0, 8'h11);
      @(negedge clk);
      write_reg(3'd0, 8'h22);
      total_cnt++;
      if (TxRDYn !== 1'b1) $display("FAIL b2b_full: got %b expected 1", TxRDYn);
      else pass_cnt++;
      write_reg(3'd0, 8'h33);
      repeat (2518) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (SOUT !== exp_frame[i]) $display("FAIL b2b_bit%0d: got %b expected %b", i, SOUT, exp_frame[i]);
         else pass_cnt++;
         if (i < 9) repeat (240) @(negedge clk);
      end
      repeat (130) @(negedge clk);
      total_cnt++;
      if ({DDIS, TxRDYn} !== 2'b10) $display("FAIL b2b_drop: got DDIS/TxRDYn %b expected 10", {DDIS, TxRDYn});
      else pass_cnt++;
   endtask

   task automatic test_rx;
      total_cnt++;
      if (RxRDYn !== 1'b1) $display("FAIL rx_idle: got %b expected 1", RxRDYn);
      else pass_cnt++;
      send_byte(8'h01, 1'b1);
      total_cnt++;
      if (RxRDYn !== 1'b0) $display("FAIL rx_ready: got %b expected 0", RxRDYn);
      else pass_cnt++;
      I_RX_EN = 1'b1; I_RADDR = 3'd0; #1;
      total_cnt++;
      if (O_RDATA !== 8'h01) $display("FAIL rx_data: got %h expected 01", O_RDATA);
      else pass_cnt++;
      @(negedge clk);
      I_RX_EN = 1'b0;
      total_cnt++;
      if (RxRDYn !== 1'b1) $display("FAIL rx_pop: got %b expected 1", RxRDYn);
      else pass_cnt++;
   endtask

   task automatic test_overrun;
      send_byte(8'h2C, 1'b1);
      send_byte(8'h16, 1'b1);
      I_RX_EN = 1'b1; I_RADDR = 3'd5; #1;
      total_cnt++;
      if (O_RDATA !== 8'h63) $display("FAIL ovr_lsr1: got %h expected 63", O_RDATA);
      else pass_cnt++;
      @(negedge clk);
      I_RX_EN = 1'b0; #1;
      total_cnt++;
      if (O_RDATA !== 8'h61) $display("FAIL ovr_lsr2: got %h expected 61", O_RDATA);
      else pass_cnt++;
      I_RADDR = 3'd0; #1;
      total_cnt++;
      if (O_RDATA !== 8'h2C) $display("FAIL ovr_rhr: got %h expected 2c", O_RDATA);
      else pass_cnt++;
      I_RX_EN = 1'b1;
      @(negedge clk);
      I_RX_EN = 1'b0;
   endtask

   task automatic test_frame_error;
      send_byte(8'hA5, 1'b0);
      I_RADDR = 3'd5; #1;
      total_cnt++;
      if (O_RDATA !== 8'h69) $display("FAIL fe_lsr: got %h expected 69", O_RDATA);
      else pass_cnt++;
      I_RADDR = 3'd0; #1;
      total_cnt++;
      if (O_RDATA !== 8'hA5 || RxRDYn !== 1'b0) $display("FAIL fe_data: got %h/%b expected a5/0", O_RDATA, RxRDYn);
      else pass_cnt++;
      I_RX_EN = 1'b1; I_RADDR = 3'd5;
      @(negedge clk);
      I_RADDR = 3'd0;
      @(negedge clk);
      I_RX_EN = 1'b0; I_RADDR = 3'd5; #1;
      total_cnt++;
      if (O_RDATA !== 8'h60) $display("FAIL fe_clear: got %h expected 60", O_RDATA);
      else pass_cnt++;
   endtask

   task automatic test_intr;
      write_reg(3'd1, 8'h01);
      total_cnt++;
      if (INTR !== 1'b0) $display("FAIL intr_idle: got %b expected 0", INTR);
      else pass_cnt++;
      send_byte(8'h5A, 1'b1);
      I_RADDR = 3'd2; #1;
      total_cnt++;
      if (INTR !== 1'b1 || O_RDATA !== 8'h04) $display("FAIL intr_rda: got %b/%h expected 1/04", INTR, O_RDATA);
      else pass_cnt++;
      I_RX_EN = 1'b1; I_RADDR = 3'd0;
      @(negedge clk);
      I_RX_EN = 1'b0; I_RADDR = 3'd2; #1;
      total_cnt++;
      if (INTR !== 1'b0 || O_RDATA !== 8'h02) $display("FAIL intr_clear: got %b/%h expected 0/02", INTR, O_RDATA);
      else pass_cnt++;
      write_reg(3'd1, 8'h02);
      total_cnt++;
      if (INTR !== 1'b1) $display("FAIL intr_thre: got %b expected 1", INTR);
      else pass_cnt++;
      write_reg(3'd1, 8'h00);
   endtask

   task automatic test_reset_mid_tx;
      write_reg(3'd4, 8'h01);
      write_reg(3'd0, 8'h00);
      repeat (100) @(negedge clk);
      total_cnt++;
      if ({SOUT, DDIS} !== 2'b00) $display("FAIL midtx_busy: got SOUT/DDIS %b expected 00", {SOUT, DDIS});
      else pass_cnt++;
      I_RESET = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({SOUT, TxRDYn, DDIS, DTRn} !== 4'b1011) $display("FAIL midtx_reset: got %b expected 1011", {SOUT, TxRDYn, DDIS, DTRn});
      else pass_cnt++;
      I_RESET = 1'b0;
      repeat (300) @(negedge clk);
      total_cnt++;
      if ({SOUT, DDIS} !== 2'b11) $display("FAIL midtx_stay_idle: got %b expected 11", {SOUT, DDIS});
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_regs;
      test_tx;
      test_back_to_back;
      test_rx;
      test_overrun;
      test_frame_error;
      test_intr;
      test_reset_mid_tx;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
